// File: rtl/vga_pkg.sv
// Shared pixel type and frame-FIFO state encoding for the video output chain.
package vga_pkg;

  localparam int H_SIZE = 10;
  localparam int V_SIZE = 10;
  localparam int R_SIZE = 8;
  localparam int G_SIZE = 8;
  localparam int B_SIZE = 8;

  typedef struct packed {
    logic [H_SIZE-1:0] hc;
    logic [V_SIZE-1:0] vc;
    logic              start;
    logic [R_SIZE-1:0] r;
    logic [G_SIZE-1:0] g;
    logic [B_SIZE-1:0] b;
  } vga_frame_t;

  typedef enum logic [1:0] {
    SEEK     = 2'd0,
    WAIT_SOF = 2'd1,
    RUN      = 2'd2
  } fifo_state_t;

  // Black pixel that keeps the head's coordinates so the sink can still track position.
  function automatic vga_frame_t filler_of(input vga_frame_t head, input logic head_valid);
    vga_frame_t f;
    f = '0;
    if (head_valid) begin
      f.hc    = head.hc;
      f.vc    = head.vc;
      f.start = head.start;
    end
    return f;
  endfunction

endpackage

// File: rtl/video_frame_fifo_if.sv
// Pixel stream in from the last video core and pixel pull out to the VGA sync block.
interface video_frame_fifo_if;
  // source_vld pushes source_frame every cycle it is high (no ready; stall_out is the
  // registered back-pressure upstream must honour). sink_req pulls one pixel per cycle,
  // and sink_vld/sink_frame answer it on the following cycle.
  logic                 source_vld;
  vga_pkg::vga_frame_t  source_frame;
  logic                 stall_out;
  logic                 sink_req;
  logic                 sink_sof;
  logic                 sink_vld;
  vga_pkg::vga_frame_t  sink_frame;

  modport master (
    output source_vld, source_frame, sink_req, sink_sof,
    input  stall_out, sink_vld, sink_frame
  );

  modport slave (
    input  source_vld, source_frame, sink_req, sink_sof,
    output stall_out, sink_vld, sink_frame
  );
endinterface

// File: rtl/video_fifo_mem.sv
// Simple dual-port pixel storage: synchronous write, combinational read of the head entry.
module video_fifo_mem
  import vga_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  vga_frame_t    wdata,
  input  logic [AW-1:0] raddr,
  output vga_frame_t    rdata
);

  vga_frame_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/video_frame_fifo.sv
// Frame-aligned output FIFO between the last video core and the VGA sync block.
module video_frame_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AFULL = 12,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                clk,
  input  logic                rst,
  video_frame_fifo_if.slave   bus,
  output logic                overflow,
  output logic                underflow,
  output logic [LW-1:0]       level,
  output fifo_state_t         fsm_state
);

  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  vga_frame_t    head;
  logic          head_valid;
  logic          wr_en;
  logic          pop;
  logic [LW-1:0] level_nxt;
  fifo_state_t   state;
  logic          stall_q;
  logic          sink_vld_q;
  vga_frame_t    sink_frame_q;

  video_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.source_frame),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign head_valid = (level != '0);
  // A pop in the same cycle does not free a slot for this write: full stays full one cycle.
  assign wr_en      = bus.source_vld && (level < FULL_LVL);

  always_comb begin
    pop = 1'b0;
    case (state)
      SEEK:     pop = head_valid && !head.start;
      WAIT_SOF: pop = bus.sink_req && bus.sink_sof && head_valid;
      RUN:      pop = bus.sink_req && head_valid &&
                      !(bus.sink_sof && !head.start) &&
                      !(!bus.sink_sof && head.start);
      default:  pop = 1'b0;
    endcase
  end

  always_comb begin
    level_nxt = level;
    if (wr_en && !pop)      level_nxt = level + LW'(1);
    else if (!wr_en && pop) level_nxt = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      state        <= SEEK;
      stall_q      <= 1'b0;
      sink_vld_q   <= 1'b0;
      sink_frame_q <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      level   <= level_nxt;
      stall_q <= (level_nxt >= AFULL_LVL);
      if (bus.source_vld && (level == FULL_LVL)) overflow <= 1'b1;
      if ((state == RUN) && bus.sink_req && !head_valid) underflow <= 1'b1;

      // Pops in SEEK are discards, so only WAIT_SOF/RUN pops reach the display.
      sink_vld_q <= 1'b0;
      if (bus.sink_req) begin
        sink_vld_q   <= pop && (state != SEEK);
        sink_frame_q <= (pop && (state != SEEK)) ? head : filler_of(head, head_valid);
      end

      case (state)
        SEEK: begin
          if (head_valid && head.start) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (bus.sink_req && bus.sink_sof && head_valid) state <= RUN;
        end
        RUN: begin
          if (bus.sink_req && head_valid) begin
            if (bus.sink_sof && !head.start)      state <= SEEK;
            else if (!bus.sink_sof && head.start) state <= WAIT_SOF;
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

  assign bus.stall_out  = stall_q;
  assign bus.sink_vld   = sink_vld_q;
  assign bus.sink_frame = sink_frame_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_video_frame_fifo.sv
// Directed scenarios plus random traffic for video_frame_fifo against a queue-based model.
module tb_video_frame_fifo;
  import vga_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int FW    = $bits(vga_frame_t);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       overflow;
  logic       underflow;
  logic [4:0] level;
  fifo_state_t fsm_state;

  video_frame_fifo_if bus();

  video_frame_fifo #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .overflow  (overflow),
    .underflow (underflow),
    .level     (level),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: pixel queue plus the alignment phase and output registers.
  logic [FW-1:0] exp_q[$];
  fifo_state_t   m_state;
  logic          m_ovf, m_unf, m_vld, m_stall;
  vga_frame_t    m_frame;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic vga_frame_t pix(input logic start, input logic [7:0] c);
    vga_frame_t p;
    p.hc    = 10'($urandom_range(0, 1023));
    p.vc    = 10'($urandom_range(0, 1023));
    p.start = start;
    p.r     = c;
    p.g     = c;
    p.b     = c;
    return p;
  endfunction

  task automatic model_step(input logic v, input vga_frame_t f, input logic req,
                            input logic sof, input logic r);
    logic       has, take, show;
    vga_frame_t hd, fl;
    if (r) begin
      exp_q.delete();
      m_state = SEEK;
      m_ovf = 0; m_unf = 0; m_vld = 0; m_stall = 0;
      m_frame = '0;
      return;
    end
    has  = exp_q.size() > 0;
    hd   = has ? vga_frame_t'(exp_q[0]) : vga_frame_t'('0);
    take = 0;
    show = 0;
    fl   = '0;
    if (has) begin
      fl.hc = hd.hc; fl.vc = hd.vc; fl.start = hd.start;
    end
    case (m_state)
      SEEK: begin
        if (has && !hd.start) take = 1;
        else if (has) m_state = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (req && sof && has) begin
          take = 1; show = 1; m_state = RUN;
        end
      end
      default: begin
        if (req) begin
          if (!has) m_unf = 1;
          else if (sof && !hd.start) m_state = SEEK;
          else if (!sof && hd.start) m_state = WAIT_SOF;
          else begin
            take = 1; show = 1;
          end
        end
      end
    endcase
    m_vld = req && show;
    if (req) m_frame = show ? hd : fl;
    if (v && exp_q.size() == DEPTH) m_ovf = 1;
    if (take) void'(exp_q.pop_front());
    if (v && exp_q.size() + (take ? 1 : 0) < DEPTH) exp_q.push_back(f);
    m_stall = exp_q.size() >= AFULL;
  endtask

  task automatic cycle(input logic v, input vga_frame_t f, input logic req,
                       input logic sof, input logic r);
    @(negedge clk);
    rst              = r;
    bus.source_vld   = v;
    bus.source_frame = f;
    bus.sink_req     = req;
    bus.sink_sof     = sof;
    model_step(v, f, req, sof, r);
    @(posedge clk);
    #1;
    check("level", 64'(level), 64'(exp_q.size()));
    check("stall_out", 64'(bus.stall_out), 64'(m_stall));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("underflow", 64'(underflow), 64'(m_unf));
    check("sink_vld", 64'(bus.sink_vld), 64'(m_vld));
    check("sink_frame", 64'(bus.sink_frame), 64'(m_frame));
    check("state", 64'(fsm_state), 64'(m_state));
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic write(input vga_frame_t p);
    cycle(1'b1, p, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic request(input logic sof);
    cycle(1'b0, '0, 1'b1, sof, 1'b0);
  endtask

  initial begin
    bus.source_vld   = 0;
    bus.source_frame = '0;
    bus.sink_req     = 0;
    bus.sink_sof     = 0;

    // Reset state
    do_reset();
    check("rst_level", 64'(level), 64'd0);
    check("rst_sink_frame", 64'(bus.sink_frame), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(SEEK));

    // Aligned start
    for (int i = 0; i < 8; i++) write(pix(i == 0, 8'(8'h10 + i)));
    for (int i = 0; i < 8; i++) begin
      request(i == 0);
      check("aligned_vld", 64'(bus.sink_vld), 64'd1);
      check("aligned_r", 64'(bus.sink_frame.r), 64'(8'h10 + i));
    end
    check("aligned_unf", 64'(underflow), 64'd0);

    // Backpressure and overflow
    do_reset();
    for (int i = 0; i < 17; i++) begin
      write(pix(i == 0, 8'(i)));
      if (i == 10) check("bp_stall_lo", 64'(bus.stall_out), 64'd0);
      if (i == 11) check("bp_stall_hi", 64'(bus.stall_out), 64'd1);
      if (i == 15) check("bp_full_noovf", 64'(overflow), 64'd0);
    end
    check("bp_level", 64'(level), 64'd16);
    check("bp_ovf", 64'(overflow), 64'd1);

    // Underflow in RUN
    do_reset();
    write(pix(1'b1, 8'h55));
    idle();
    request(1'b1);
    check("unf_pre_state", 64'(fsm_state), 64'(RUN));
    request(1'b0);
    check("unf_vld", 64'(bus.sink_vld), 64'd0);
    check("unf_rgb", 64'({bus.sink_frame.r, bus.sink_frame.g, bus.sink_frame.b}), 64'd0);
    check("unf_flag", 64'(underflow), 64'd1);
    check("unf_state", 64'(fsm_state), 64'(RUN));

    // Leading garbage
    do_reset();
    for (int i = 0; i < 3; i++) write(pix(1'b0, 8'h20));
    write(pix(1'b1, 8'h77));
    idle();
    check("garb_level", 64'(level), 64'd1);
    check("garb_state", 64'(fsm_state), 64'(WAIT_SOF));
    request(1'b0);
    check("garb_filler", 64'(bus.sink_vld), 64'd0);
    request(1'b1);
    check("garb_start_vld", 64'(bus.sink_vld), 64'd1);
    check("garb_start_r", 64'(bus.sink_frame.r), 64'h77);

    // Misalignment: sync at start of frame while head is mid-frame
    write(pix(1'b0, 8'h31));
    write(pix(1'b0, 8'h32));
    request(1'b1);
    check("mis_vld", 64'(bus.sink_vld), 64'd0);
    check("mis_state", 64'(fsm_state), 64'(SEEK));
    idle();
    idle();
    check("mis_drained", 64'(level), 64'd0);
    write(pix(1'b1, 8'h40));
    idle();
    check("mis_resync", 64'(fsm_state), 64'(WAIT_SOF));

    // Reset mid-frame
    do_reset();
    for (int i = 0; i < 11; i++) write(pix(i == 0, 8'(i)));
    request(1'b1);
    check("mid_level", 64'(level), 64'd10);
    check("mid_state", 64'(fsm_state), 64'(RUN));
    do_reset();
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_stall", 64'(bus.stall_out), 64'd0);
    check("mid_rst_flags", 64'({overflow, underflow}), 64'd0);
    check("mid_rst_state", 64'(fsm_state), 64'(SEEK));

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic v, req, sof, r;
      v   = $urandom_range(0, 9) < 7;
      req = $urandom_range(0, 9) < 6;
      sof = $urandom_range(0, 9) < 2;
      r   = $urandom_range(0, 299) == 0;
      cycle(v, pix($urandom_range(0, 9) == 0, 8'($urandom_range(0, 255))), req, sof, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
